extreme_pool: RTL and testbench

Sequential holding pool that collects data words from a producer and hands them out one at a time in min-first or max-first order. It is the storage side of the binary-tree extreme finder: it owns the entry slots and valid bits, presents the current extreme of the occupied slots, and removes that entry when a consumer takes it. It is used wherever a small scheduler needs "give me the smallest/largest pending item", such as age-ordered issue or priority-ordered retire.

---
 rtl/extreme_pool.sv | 128 ++++++++++++
 tb/tb_extreme_pool.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/extreme_pool.sv
`default_nettype none
// ============================================================================
// extreme_pool : slot pool presenting the min (or max) occupied entry
//                through a comparator tree; pop removes the presented entry.
// Revision 1.0
// ============================================================================
module extreme_pool #(
    parameter int LEVEL      = 3,
    parameter int DATA_SZ    = 4,
    parameter int COMPARATOR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [DATA_SZ-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_SZ-1:0] out_data,
    output logic [LEVEL-2:0]   out_slot,
    input  logic               out_ready,
    output logic [LEVEL-1:0]   count
);

    localparam int ENTRIES = 1 << (LEVEL - 1);
    localparam int NODES   = 2 * ENTRIES - 1;
    localparam int SLOT_W  = LEVEL - 1;
    localparam logic [LEVEL-1:0] FULL_COUNT = LEVEL'(ENTRIES);

    logic [DATA_SZ-1:0] data_q [ENTRIES];
    logic [DATA_SZ-1:0] data_d [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [LEVEL-1:0]   count_q, count_d;

    // Heap-ordered tree: node n has children 2n+1 / 2n+2, leaves start at ENTRIES-1.
    logic [DATA_SZ-1:0] w_node_val  [NODES];
    logic [SLOT_W-1:0]  w_node_slot [NODES];
    logic [NODES-1:0]   w_node_vld;
    logic               w_better;
    logic               w_pick_right;

    logic              w_push;
    logic              w_pop;
    logic [SLOT_W-1:0] w_free_slot;

    always_comb begin
        w_better     = 1'b0;
        w_pick_right = 1'b0;
        w_node_vld   = '0;
        for (int n = 0; n < NODES; n++) begin
            w_node_val[n]  = '0;
            w_node_slot[n] = '0;
        end
        for (int i = 0; i < ENTRIES; i++) begin
            w_node_val[ENTRIES-1+i]  = data_q[i];
            w_node_slot[ENTRIES-1+i] = SLOT_W'(i);
            w_node_vld[ENTRIES-1+i]  = valid_q[i];
        end
        for (int n = ENTRIES - 2; n >= 0; n--) begin
            // Strict compare keeps ties on the left (lower slot index).
            if (COMPARATOR != 0) begin
                w_better = w_node_val[2*n+2] > w_node_val[2*n+1];
            end else begin
                w_better = w_node_val[2*n+2] < w_node_val[2*n+1];
            end
            w_pick_right = w_node_vld[2*n+2] && (!w_node_vld[2*n+1] || w_better);
            if (w_pick_right) begin
                w_node_val[n]  = w_node_val[2*n+2];
                w_node_slot[n] = w_node_slot[2*n+2];
            end else begin
                w_node_val[n]  = w_node_val[2*n+1];
                w_node_slot[n] = w_node_slot[2*n+1];
            end
            w_node_vld[n] = w_node_vld[2*n+1] || w_node_vld[2*n+2];
        end
    end

    always_comb begin
        w_free_slot = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_free_slot = SLOT_W'(i);
            end
        end
    end

    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? w_node_val[0]  : '0;
    assign out_slot  = out_valid ? w_node_slot[0] : '0;
    assign count     = count_q;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Free slot comes from pre-pop state, so a same-cycle push never reuses out_slot.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < ENTRIES; i++) begin
            data_d[i] = data_q[i];
        end
        if (w_pop) begin
            valid_d[out_slot] = 1'b0;
        end
        if (w_push) begin
            valid_d[w_free_slot] = 1'b1;
            data_d[w_free_slot]  = in_data;
        end
        count_d = count_q + LEVEL'(w_push) - LEVEL'(w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < ENTRIES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_extreme_pool.sv
`default_nettype none
// ============================================================================
// tb_extreme_pool : directed and randomized checks of extreme_pool against
//                   a slot-level reference model.
// Revision 1.0
// ============================================================================
module tb_extreme_pool;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_in_valid = 1'b0;
    logic [3:0] a_in_data  = '0;
    logic       a_out_ready = 1'b0;
    logic       a_in_ready, a_out_valid;
    logic [3:0] a_out_data;
    logic [1:0] a_out_slot;
    logic [2:0] a_count;

    logic       b_in_valid = 1'b0;
    logic [3:0] b_in_data  = '0;
    logic       b_out_ready = 1'b0;
    logic       b_in_ready, b_out_valid;
    logic [3:0] b_out_data;
    logic [1:0] b_out_slot;
    logic [2:0] b_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] m_data  [4];
    logic       m_valid [4];

    extreme_pool #(.LEVEL(3), .DATA_SZ(4), .COMPARATOR(0)) u_min (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_slot(a_out_slot),
        .out_ready(a_out_ready), .count(a_count)
    );

    extreme_pool #(.LEVEL(3), .DATA_SZ(4), .COMPARATOR(1)) u_max (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_slot(b_out_slot),
        .out_ready(b_out_ready), .count(b_count)
    );

    always #5 clk = ~clk;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 4; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    // Smallest occupied value; earliest slot wins among equals.
    function automatic void m_best(output logic v, output logic [3:0] d, output logic [1:0] s);
        v = 1'b0; d = '0; s = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && (!v || m_data[i] < d)) begin
                v = 1'b1; d = m_data[i]; s = 2'(i);
            end
        end
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
        end
    endfunction

    // One clock of stimulus on the min pool; model follows the push/pop rules.
    task automatic cycle_a(input logic iv, input logic [3:0] id, input logic ordy);
        logic push, pop, bv;
        logic [3:0] bd;
        logic [1:0] bs;
        int fs;
        a_in_valid = iv; a_in_data = id; a_out_ready = ordy;
        push = iv && (m_count() < 4);
        pop  = ordy && (m_count() != 0);
        m_best(bv, bd, bs);
        fs = -1;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) fs = i;
        @(posedge clk); #1;
        if (pop) m_valid[bs] = 1'b0;
        if (push) begin
            m_valid[fs] = 1'b1;
            m_data[fs]  = id;
        end
        a_in_valid = 1'b0; a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_clear();
        #1;
        n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0d expected 1", a_in_ready); end
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0d expected 0", a_out_valid); end
        n_checks++; if (a_out_data !== 4'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", a_out_data); end
        n_checks++; if (a_out_slot !== 2'd0) begin n_fail++; $display("FAIL reset_out_slot: got %0d expected 0", a_out_slot); end
        n_checks++; if (b_out_valid !== 1'b0 || b_count !== 3'd0) begin n_fail++; $display("FAIL reset_max: got valid %0d count %0d expected 0 0", b_out_valid, b_count); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: got count %0d valid %0d expected 0 0", a_count, a_out_valid); end
    endtask

    task automatic test_ordering();
        logic [3:0] pv [4] = '{4'd9, 4'd3, 4'd12, 4'd3};
        logic [3:0] ed [4] = '{4'd3, 4'd3, 4'd9, 4'd12};
        logic [1:0] es [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
        for (int i = 0; i < 4; i++) cycle_a(1'b1, pv[i], 1'b0);
        n_checks++; if (a_count !== 3'd4) begin n_fail++; $display("FAIL order_count: got %0d expected 4", a_count); end
        n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL order_full_ready: got %0d expected 0", a_in_ready); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== ed[i] || a_out_slot !== es[i]) begin
                n_fail++;
                $display("FAIL order_pop%0d: got v%0d %0d slot %0d expected v1 %0d slot %0d",
                         i, a_out_valid, a_out_data, a_out_slot, ed[i], es[i]);
            end
            cycle_a(1'b0, 4'd0, 1'b1);
        end
        n_checks++; if (a_out_valid !== 1'b0 || a_count !== 3'd0) begin n_fail++; $display("FAIL order_drained: got valid %0d count %0d expected 0 0", a_out_valid, a_count); end
    endtask

    task automatic test_max();
        logic [3:0] pv [3] = '{4'd5, 4'd15, 4'd0};
        logic [3:0] ev [3] = '{4'd15, 4'd5, 4'd0};
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1; b_in_data = pv[i];
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        n_checks++; if (b_count !== 3'd3) begin n_fail++; $display("FAIL max_count: got %0d expected 3", b_count); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (b_out_valid !== 1'b1 || b_out_data !== ev[i]) begin
                n_fail++;
                $display("FAIL max_pop%0d: got v%0d %0d expected v1 %0d", i, b_out_valid, b_out_data, ev[i]);
            end
            b_out_ready = 1'b1;
            @(posedge clk); #1;
            b_out_ready = 1'b0;
        end
        n_checks++; if (b_out_valid !== 1'b0 || b_count !== 3'd0) begin n_fail++; $display("FAIL max_drained: got valid %0d count %0d expected 0 0", b_out_valid, b_count); end
    endtask

    task automatic test_simultaneous();
        cycle_a(1'b1, 4'd7, 1'b0);
        cycle_a(1'b1, 4'd2, 1'b0);
        n_checks++; if (a_out_data !== 4'd2 || a_out_slot !== 2'd1) begin n_fail++; $display("FAIL simul_pre: got %0d slot %0d expected 2 slot 1", a_out_data, a_out_slot); end
        cycle_a(1'b1, 4'd1, 1'b1);
        n_checks++; if (a_count !== 3'd2) begin n_fail++; $display("FAIL simul_count: got %0d expected 2", a_count); end
        n_checks++; if (a_out_data !== 4'd1 || a_out_slot !== 2'd2) begin n_fail++; $display("FAIL simul_out: got %0d slot %0d expected 1 slot 2", a_out_data, a_out_slot); end
        cycle_a(1'b0, 4'd0, 1'b1);
        n_checks++; if (a_out_data !== 4'd7 || a_out_slot !== 2'd0) begin n_fail++; $display("FAIL simul_next: got %0d slot %0d expected 7 slot 0", a_out_data, a_out_slot); end
        cycle_a(1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_full();
        logic [3:0] pv [4] = '{4'd8, 4'd6, 4'd10, 4'd11};
        for (int i = 0; i < 4; i++) cycle_a(1'b1, pv[i], 1'b0);
        cycle_a(1'b1, 4'd4, 1'b1);
        n_checks++; if (a_count !== 3'd3) begin n_fail++; $display("FAIL full_count: got %0d expected 3", a_count); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise: got %0d expected 1", a_in_ready); end
        n_checks++; if (a_out_data !== 4'd8 || a_out_slot !== 2'd0) begin n_fail++; $display("FAIL full_no_push: got %0d slot %0d expected 8 slot 0", a_out_data, a_out_slot); end
        cycle_a(1'b1, 4'd4, 1'b0);
        n_checks++; if (a_count !== 3'd4 || a_out_data !== 4'd4 || a_out_slot !== 2'd1) begin n_fail++; $display("FAIL full_push_next: got count %0d %0d slot %0d expected 4 4 slot 1", a_count, a_out_data, a_out_slot); end
        for (int i = 0; i < 4; i++) cycle_a(1'b0, 4'd0, 1'b1);
        n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL full_drain: got %0d expected 0", a_count); end
    endtask

    task automatic test_empty();
        a_in_valid = 1'b1; a_in_data = 4'd6; a_out_ready = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_no_bypass: got %0d expected 0", a_out_valid); end
        cycle_a(1'b1, 4'd6, 1'b1);
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 4'd6 || a_out_slot !== 2'd0) begin n_fail++; $display("FAIL empty_push: got v%0d %0d slot %0d expected v1 6 slot 0", a_out_valid, a_out_data, a_out_slot); end
        n_checks++; if (a_count !== 3'd1) begin n_fail++; $display("FAIL empty_count: got %0d expected 1", a_count); end
        cycle_a(1'b0, 4'd0, 1'b1);
        cycle_a(1'b0, 4'd0, 1'b1);
        n_checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_underflow: got count %0d valid %0d expected 0 0", a_count, a_out_valid); end
    endtask

    task automatic test_random();
        logic bv;
        logic [3:0] bd;
        logic [1:0] bs;
        int ec;
        for (int k = 0; k < 400; k++) begin
            m_best(bv, bd, bs);
            ec = m_count();
            n_checks++;
            if (a_count !== 3'(ec) || a_in_ready !== (ec < 4) || a_out_valid !== bv ||
                a_out_data !== bd || a_out_slot !== bs) begin
                n_fail++;
                $display("FAIL rand_%0d: got count %0d rdy %0d v%0d %0d slot %0d expected count %0d rdy %0d v%0d %0d slot %0d",
                         k, a_count, a_in_ready, a_out_valid, a_out_data, a_out_slot,
                         ec, (ec < 4), bv, bd, bs);
            end
            cycle_a(($urandom % 100) < 55, 4'($urandom_range(0, 15)), ($urandom % 100) < 45);
        end
    endtask

    task automatic test_reset_midop();
        for (int k = 0; k < 8 && m_count() > 0; k++) cycle_a(1'b0, 4'd0, 1'b1);
        cycle_a(1'b1, 4'd5, 1'b0);
        cycle_a(1'b1, 4'd1, 1'b0);
        cycle_a(1'b1, 4'd9, 1'b0);
        n_checks++; if (a_count !== 3'd3) begin n_fail++; $display("FAIL midrst_pre: got %0d expected 3", a_count); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (a_count !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d expected 0", a_count); end
        n_checks++; if (a_out_valid !== 1'b0 || a_out_data !== 4'd0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_outs: got v%0d %0d rdy %0d expected v0 0 rdy 1", a_out_valid, a_out_data, a_in_ready); end
        #2 rst_n = 1'b1;
        m_clear();
        @(posedge clk); #1;
        n_checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_after: got count %0d valid %0d expected 0 0", a_count, a_out_valid); end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_max();
        test_simultaneous();
        test_full();
        test_empty();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
